fb_fill_ctrl: RTL and testbench
===============================

Name: fb_fill_ctrl

Overview:
- Memory-mapped fill engine for the VGA framebuffer. The CPU programs a destination, a length and a colour, then starts a fill.
- The engine writes that colour into consecutive framebuffer words, one word per cycle.
- It sits between the CPU data-memory write path and the framebuffer write port. It arbitrates between CPU framebuffer stores and engine stores. CPU stores always win.

Parameters:
- FB_AW, 19, framebuffer word-address width (640x480 pixels = 307200 words).
- PIX_W, 12, pixel width in bits (4:4:4 RGB).

Ports:
- clock  in  1  system clock; all state changes on its rising edge
- clrn  in  1  synchronous active-low reset, sampled on rising edge of clock
- reg_sel  in  1  MMIO select for the 4-register control window
- reg_we  in  1  register write strobe, qualified by reg_sel
- reg_addr  in  2  register index (dmemaddr[3:2]): 0 DST, 1 LEN, 2 COLOR, 3 CTRL/STATUS
- reg_din  in  32  register write data
- reg_dout  out  32  combinational read data for reg_addr
- cpu_fb_we  in  1  CPU framebuffer store this cycle
- cpu_fb_addr  in  FB_AW  CPU store word address
- cpu_fb_din  in  PIX_W  CPU store pixel
- fb_we  out  1  framebuffer write enable
- fb_addr  out  FB_AW  framebuffer write address
- fb_din  out  PIX_W  framebuffer write data
- busy  out  1  engine in RUN
- done  out  1  sticky completion flag

Behaviour:

Registers:
- DST: FB_AW bits, from reg_din[FB_AW-1:0].
- LEN: FB_AW+1 bits, word count, from reg_din[FB_AW:0].
- COLOR: PIX_W bits.
- CTRL write bits:
  - bit0 = start
  - bit1 = abort
  - bit2 = clear done
- STATUS read value: {30'b0, done, busy}.
- Reads of DST, LEN and COLOR return the programmed values, zero-extended.

Write rules:
- Writes to DST, LEN or COLOR while busy=1 are ignored.

Reset (clrn=0 at an edge):
- state=IDLE; DST, LEN, COLOR, cur_addr and remain all 0; busy=0; done=0.
- From the following cycle, no engine writes are issued.
- Reset mid-fill abandons the fill, with no further engine writes.

FSM, IDLE:
- CTRL write with start=1 and LEN!=0:
  - cur_addr<=DST, remain<=LEN, done<=0, state<=RUN.
- Start with LEN==0:
  - stays IDLE, done<=1, no writes.
- Abort in IDLE: no effect.

FSM, RUN:
- busy=1.
- Each cycle with cpu_fb_we=0, the engine owns the port:
  - fb_we=1, fb_addr=cur_addr, fb_din=COLOR.
  - At the edge: cur_addr<=cur_addr+1 (wraps modulo 2^FB_AW), remain<=remain-1.
- When a write is issued with remain==1:
  - state<=IDLE, done<=1 at that edge.
- Cycles with cpu_fb_we=1 stall the engine; cur_addr and remain are held.
- CTRL write with abort=1: state<=IDLE at that edge, done unchanged.
  - The engine write in the same cycle still commits, unless the CPU owns the port.
- Start while busy is ignored.

Arbitration (combinational):
- cpu_fb_we=1: fb_we=1, fb_addr=cpu_fb_addr, fb_din=cpu_fb_din.
- Otherwise: engine values if RUN, else fb_we=0, fb_addr=0, fb_din=0.

Simultaneous CTRL bits:
- start+abort: abort takes priority if busy; if idle, no start occurs.
- start+clear: done cleared and the fill starts.
- clear together with the completion edge: completion wins, done=1.

Timing:
- Start written at edge k.
- First engine write is in cycle k+1.
- With no CPU contention, a fill of N words occupies cycles k+1..k+N.
- busy falls and done rises after edge k+N.

Test Plan:
- Reset: DST=0x100, LEN=4, COLOR=0xF00, start. Expected:
  - Writes 0xF00 to addresses 0x100..0x103 in 4 consecutive cycles.
  - busy high for exactly 4 cycles.
  - done=1 afterwards; STATUS reads 0x2.
- CPU contention: same fill, with cpu_fb_we=1 (addr 0x5, data 0x0AB) in the 2nd fill cycle. Expected:
  - That cycle outputs the CPU write.
  - Engine writes 0x100..0x103 still all occur, in 5 cycles total.
- Wrap: DST=2^19-2, LEN=4. Expected:
  - Writes to 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
  - done=1.
- Zero length: LEN=0, start. Expected:
  - No fb_we from the engine.
  - busy stays 0; done=1 on the next cycle.
- Abort: LEN=100; abort written in the 10th fill cycle. Expected:
  - Exactly 10 engine writes; busy=0; done=0.
  - DST write after the abort takes effect; a DST write while busy reads back unchanged.
- Reset mid-run: clrn=0 during the 3rd cycle of a LEN=50 fill. Expected:
  - Engine writes stop the following cycle.
  - All registers read 0; busy=0; done=0.

Source files
------------

// File: rtl/fb_fill_ctrl.sv
// VGA framebuffer fill engine: the CPU programs DST/LEN/COLOR over MMIO and starts a fill.
// CPU framebuffer stores always take the write port; the engine stalls while they do.
module fb_fill_ctrl #(
   parameter int FB_AW = 19,
   parameter int PIX_W = 12
) (
   input  logic             clock,
   input  logic             clrn,
   input  logic             reg_sel,
   input  logic             reg_we,
   input  logic [1:0]       reg_addr,
   input  logic [31:0]      reg_din,
   output logic [31:0]      reg_dout,
   input  logic             cpu_fb_we,
   input  logic [FB_AW-1:0] cpu_fb_addr,
   input  logic [PIX_W-1:0] cpu_fb_din,
   output logic             fb_we,
   output logic [FB_AW-1:0] fb_addr,
   output logic [PIX_W-1:0] fb_din,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state;
   logic [FB_AW-1:0] dst;
   logic [FB_AW-1:0] cur_addr;
   logic [FB_AW:0]   len;
   logic [FB_AW:0]   remain;
   logic [PIX_W-1:0] color;
   logic             reg_wr;
   logic             ctrl_wr;
   logic             eng_wr;
   logic             unused_din;

   assign reg_wr     = reg_sel & reg_we;
   assign ctrl_wr    = reg_wr & (reg_addr == 2'd3);
   assign eng_wr     = (state == RUN) & ~cpu_fb_we;
   assign busy       = (state == RUN);
   assign unused_din = ^reg_din[31:FB_AW+1];

   // Later assignments in this block deliberately override earlier ones:
   // start/completion setting done wins over a clear in the same write.
   always_ff @(posedge clock) begin
      if (!clrn) begin
         state    <= IDLE;
         dst      <= '0;
         len      <= '0;
         color    <= '0;
         cur_addr <= '0;
         remain   <= '0;
         done     <= 1'b0;
      end else begin
         if (reg_wr && state == IDLE) begin
            case (reg_addr)
               2'd0:    dst   <= reg_din[FB_AW-1:0];
               2'd1:    len   <= reg_din[FB_AW:0];
               2'd2:    color <= reg_din[PIX_W-1:0];
               default: ;
            endcase
         end
         if (ctrl_wr && reg_din[2])
            done <= 1'b0;
         case (state)
            IDLE: begin
               if (ctrl_wr && reg_din[0] && !reg_din[1]) begin
                  if (len != '0) begin
                     cur_addr <= dst;
                     remain   <= len;
                     done     <= 1'b0;
                     state    <= RUN;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (eng_wr) begin
                  cur_addr <= cur_addr + FB_AW'(1);
                  remain   <= remain - (FB_AW+1)'(1);
                  if (remain == (FB_AW+1)'(1)) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
               if (ctrl_wr && reg_din[1])
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      reg_dout = '0;
      case (reg_addr)
         2'd0:    reg_dout = 32'(dst);
         2'd1:    reg_dout = 32'(len);
         2'd2:    reg_dout = 32'(color);
         default: reg_dout = {30'b0, done, busy};
      endcase
   end

   always_comb begin
      fb_we   = 1'b0;
      fb_addr = '0;
      fb_din  = '0;
      if (cpu_fb_we) begin
         fb_we   = 1'b1;
         fb_addr = cpu_fb_addr;
         fb_din  = cpu_fb_din;
      end else if (state == RUN) begin
         fb_we   = 1'b1;
         fb_addr = cur_addr;
         fb_din  = color;
      end
   end

endmodule

// File: tb/tb_fb_fill_ctrl.sv
// Bench for fb_fill_ctrl: table of fill vectors plus hand sequences for abort and reset mid-fill.
// Every framebuffer write is matched in order against an expected queue.
module tb_fb_fill_ctrl;

   logic        clock = 1'b0;
   logic        clrn;
   logic        reg_sel, reg_we;
   logic [1:0]  reg_addr;
   logic [31:0] reg_din, reg_dout;
   logic        cpu_fb_we;
   logic [18:0] cpu_fb_addr;
   logic [11:0] cpu_fb_din;
   logic        fb_we;
   logic [18:0] fb_addr;
   logic [11:0] fb_din;
   logic        busy, done;

   fb_fill_ctrl #(.FB_AW(19), .PIX_W(12)) dut (
      .clock(clock), .clrn(clrn), .reg_sel(reg_sel), .reg_we(reg_we),
      .reg_addr(reg_addr), .reg_din(reg_din), .reg_dout(reg_dout),
      .cpu_fb_we(cpu_fb_we), .cpu_fb_addr(cpu_fb_addr), .cpu_fb_din(cpu_fb_din),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [18:0] dst;
      logic [19:0] len;
      logic [11:0] color;
      int          stall;
      int          exp_cycles;
      logic [31:0] exp_status;
   } fill_vec_t;

   logic [30:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Scoreboard: every write on the port must be the next expected {addr, data}.
   always @(negedge clock) begin
      if (fb_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%h required=none", {fb_addr, fb_din});
         end else begin
            chk("fb_write", 32'({fb_addr, fb_din}), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      reg_sel = 1'b1; reg_we = 1'b1; reg_addr = a; reg_din = d;
      @(posedge clock); #1;
      reg_sel = 1'b0; reg_we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      reg_addr = a;
      @(negedge clock);
      d = reg_dout;
      @(posedge clock); #1;
   endtask

   task automatic run_fill(input fill_vec_t v);
      logic [31:0] d;
      int busy_cnt;
      logic timed_out;
      wr(2'd0, 32'(v.dst));
      wr(2'd1, 32'(v.len));
      wr(2'd2, 32'(v.color));
      rd(2'd0, d); chk("dst_readback", d, 32'(v.dst));
      rd(2'd1, d); chk("len_readback", d, 32'(v.len));
      rd(2'd2, d); chk("color_readback", d, 32'(v.color));
      wr(2'd3, 32'h4);
      rd(2'd3, d); chk("status_after_clear", d, 32'h0);
      for (int i = 0; i < int'(v.len); i++) begin
         if (v.stall != 0 && i == v.stall - 1)
            exp_q.push_back({19'h5, 12'h0AB});
         exp_q.push_back({v.dst + 19'(i), v.color});
      end
      wr(2'd3, 32'h1);
      busy_cnt  = 0;
      timed_out = 1'b1;
      for (int c = 1; c <= 300; c++) begin
         cpu_fb_we   = (c == v.stall);
         cpu_fb_addr = 19'h5;
         cpu_fb_din  = 12'h0AB;
         @(negedge clock);
         if (!busy) begin
            timed_out = 1'b0;
            break;
         end
         busy_cnt++;
         @(posedge clock); #1;
      end
      cpu_fb_we = 1'b0;
      chk("done_flag_next", 32'(done), 32'(v.exp_status[1]));
      @(posedge clock); #1;
      chk("fill_in_bound", 32'(timed_out), 32'h0);
      chk("busy_cycles", busy_cnt, v.exp_cycles);
      rd(2'd3, d); chk("status_after_fill", d, v.exp_status);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      fill_vec_t   vecs[6];
      logic [31:0] d;
      int          rl;

      vecs[0] = '{19'h00100, 20'd4, 12'hF00, 0, 4, 32'h2};
      vecs[1] = '{19'h00100, 20'd4, 12'hF00, 2, 5, 32'h2};
      vecs[2] = '{19'h7FFFE, 20'd4, 12'h0F0, 0, 4, 32'h2};
      vecs[3] = '{19'h00000, 20'd0, 12'h123, 0, 0, 32'h2};
      vecs[4] = '{19'h12345, 20'd7, 12'hABC, 7, 8, 32'h2};
      rl = $urandom_range(1, 8);
      vecs[5].dst   = 19'($urandom_range(0, 32'h7FFFF));
      vecs[5].len   = 20'(rl);
      vecs[5].color = 12'($urandom_range(0, 32'hFFF));
      vecs[5].stall = $urandom_range(0, rl);
      vecs[5].exp_cycles = rl + ((vecs[5].stall != 0) ? 1 : 0);
      vecs[5].exp_status = 32'h2;

      // Reset
      clrn = 1'b0; reg_sel = 1'b0; reg_we = 1'b0; reg_addr = 2'd0; reg_din = '0;
      cpu_fb_we = 1'b0; cpu_fb_addr = '0; cpu_fb_din = '0;
      repeat (2) @(posedge clock);
      #1 clrn = 1'b1;
      @(negedge clock);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      chk("reset_fb_we", 32'(fb_we), 32'h0);
      @(posedge clock); #1;
      rd(2'd0, d); chk("reset_dst", d, 32'h0);
      rd(2'd1, d); chk("reset_len", d, 32'h0);
      rd(2'd3, d); chk("reset_status", d, 32'h0);

      for (int i = 0; i < 6; i++)
         run_fill(vecs[i]);

      // Start together with abort while idle must not start; done stays set
      wr(2'd1, 32'd3);
      wr(2'd3, 32'h3);
      @(negedge clock);
      chk("start_abort_idle_busy", 32'(busy), 32'h0);
      @(posedge clock); #1;
      rd(2'd3, d); chk("start_abort_idle_status", d, 32'h2);

      // CPU store passes straight through when idle
      exp_q.push_back({19'h70001, 12'h321});
      cpu_fb_we = 1'b1; cpu_fb_addr = 19'h70001; cpu_fb_din = 12'h321;
      @(posedge clock); #1;
      cpu_fb_we = 1'b0;

      // Abort in the 10th fill cycle; DST write while busy is ignored
      wr(2'd0, 32'h200);
      wr(2'd1, 32'd100);
      wr(2'd2, 32'h00F);
      for (int i = 0; i < 10; i++)
         exp_q.push_back({19'h200 + 19'(i), 12'h00F});
      wr(2'd3, 32'h5);
      for (int c = 1; c <= 10; c++) begin
         reg_sel = (c == 5 || c == 10); reg_we = reg_sel;
         reg_addr = (c == 5) ? 2'd0 : 2'd3;
         reg_din  = (c == 5) ? 32'h333 : 32'h2;
         @(posedge clock); #1;
      end
      reg_sel = 1'b0; reg_we = 1'b0;
      @(negedge clock);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_done", 32'(done), 32'h0);
      @(posedge clock); #1;
      rd(2'd0, d); chk("dst_write_while_busy", d, 32'h200);
      wr(2'd0, 32'h444);
      rd(2'd0, d); chk("dst_write_after_abort", d, 32'h444);
      chk("abort_queue_drained", exp_q.size(), 0);

      // Reset during the 3rd fill cycle of a 50-word fill
      wr(2'd0, 32'h300);
      wr(2'd1, 32'd50);
      wr(2'd2, 32'h555);
      for (int i = 0; i < 3; i++)
         exp_q.push_back({19'h300 + 19'(i), 12'h555});
      wr(2'd3, 32'h1);
      repeat (2) begin @(posedge clock); #1; end
      clrn = 1'b0;
      @(posedge clock); #1;
      @(negedge clock);
      chk("midrst_fb_we", 32'(fb_we), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      @(posedge clock); #1;
      clrn = 1'b1;
      rd(2'd0, d); chk("midrst_dst", d, 32'h0);
      rd(2'd1, d); chk("midrst_len", d, 32'h0);
      rd(2'd2, d); chk("midrst_color", d, 32'h0);
      rd(2'd3, d); chk("midrst_status", d, 32'h0);
      repeat (5) begin @(posedge clock); #1; end
      chk("final_queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
